// File: rtl/gen_al_w2n_arb.sv
// Packet-granular round-robin arbiter feeding one wide-to-narrow aligner.
// The grant is held from the first word of a packet until its eop word is consumed.
module gen_al_w2n_arb #(
  parameter  int unsigned N_REQ     = 4,
  parameter  int unsigned DAT_IN_W  = 32,
  parameter  int unsigned DAT_OUT_W = 8,
  localparam int unsigned AL_SEL_W  = ($clog2(DAT_IN_W / DAT_OUT_W) > 0) ?
                                      $clog2(DAT_IN_W / DAT_OUT_W) : 1,
  localparam int unsigned IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req_en,
  input  logic [N_REQ-1:0]          i_req_vld,
  input  logic [N_REQ-1:0]          i_req_eop,
  input  logic [N_REQ*AL_SEL_W-1:0] i_req_last_vld_sel,
  input  logic [N_REQ*DAT_IN_W-1:0] i_req_dat,
  output logic [N_REQ-1:0]          o_req_pop,
  output logic                      o_al_us_vld,
  output logic [AL_SEL_W-1:0]       o_al_us_last_vld_sel,
  output logic [DAT_IN_W-1:0]       o_al_us_dat,
  input  logic                      i_al_us_rd_rqst,
  input  logic                      i_al_ds_rdy,
  output logic                      o_gnt_vld,
  output logic [IDX_W-1:0]          o_gnt_idx,
  output logic                      o_pkt_done
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           r_state;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] r_last_idx;
  logic             r_gnt_vld;

  logic [N_REQ-1:0] w_elig;
  logic [IDX_W-1:0] w_pick;
  logic             w_found;
  logic             w_busy;
  logic             w_beat;
  logic             w_word_done;
  logic             w_pkt_done;

  assign w_elig = i_req_en & i_req_vld;
  assign w_busy = (r_state == StBusy);

  // Search starts just after the last packet's winner, wrapping modulo N_REQ.
  always_comb begin
    int j;
    j       = 0;
    w_pick  = r_gnt_idx;
    w_found = 1'b0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      j = int'(r_last_idx) + k;
      if (j >= int'(N_REQ)) j = j - int'(N_REQ);
      if (!w_found && w_elig[j]) begin
        w_pick  = IDX_W'(j);
        w_found = 1'b1;
      end
    end
  end

  assign o_al_us_dat          = i_req_dat[r_gnt_idx*DAT_IN_W +: DAT_IN_W];
  assign o_al_us_last_vld_sel = i_req_last_vld_sel[r_gnt_idx*AL_SEL_W +: AL_SEL_W];
  assign o_al_us_vld          = w_busy & i_req_vld[r_gnt_idx];

  assign w_beat      = o_al_us_vld & i_al_ds_rdy;
  assign w_word_done = w_beat & i_al_us_rd_rqst;
  assign w_pkt_done  = w_word_done & i_req_eop[r_gnt_idx];

  always_comb begin
    o_req_pop = '0;
    if (w_word_done) o_req_pop[r_gnt_idx] = 1'b1;
  end

  assign o_pkt_done = w_pkt_done;
  assign o_gnt_vld  = r_gnt_vld;
  assign o_gnt_idx  = r_gnt_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_gnt_idx  <= '0;
      r_last_idx <= IDX_W'(N_REQ - 1);
      r_gnt_vld  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_gnt_idx <= w_pick;
            r_gnt_vld <= 1'b1;
            r_state   <= StBusy;
          end
        end
        StBusy: begin
          if (w_pkt_done) begin
            r_last_idx <= r_gnt_idx;
            r_gnt_vld  <= 1'b0;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
